alu_secuencial: RTL and testbench

Parametrised, registered ALU for the `proyecto_final` datapath. It extends the four-operation combinational ALU with XOR, signed set-less-than, a multi-cycle logical shift and a multi-cycle unsigned multiply. A start/busy/done handshake sits in front of it, and the result and flag outputs are registered. It sits between the register-file read ports and the write-back stage; the control unit stalls issue while `ocupado` is high.

---
 rtl/alu_secuencial.sv | 147 ++++++++++++++
 tb/tb_alu_secuencial.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_secuencial.sv
// Registered ALU with start/busy/done handshake: single-cycle arithmetic/logic,
// bit-serial left shift and iterative shift-add unsigned multiply.
module alu_secuencial #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inicio,
    input  logic [n-1:0] entrada1,
    input  logic [n-1:0] entrada2,
    input  logic [2:0]   alucontrol,
    output logic         ocupado,
    output logic         listo,
    output logic [n-1:0] resultado,
    output logic         carry,
    output logic         cero,
    output logic         negativo,
    output logic         desbordamiento
);

    localparam int cw = $clog2(n);

    localparam logic [2:0] OP_SUMA  = 3'b000;
    localparam logic [2:0] OP_RESTA = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_SLT   = 3'b101;
    localparam logic [2:0] OP_SLL   = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    typedef enum logic {INACTIVO, CALCULO} estado_t;

    estado_t        estado;
    logic [cw-1:0]  contador;
    logic [cw-1:0]  carga_contador;
    logic [n-1:0]   op_a;
    logic [n-1:0]   op_b;
    logic [2:0]     op_sel;
    logic [n-1:0]   desplazado;
    logic [n-1:0]   desp_sig;
    logic [2*n-1:0] acumulador;
    logic [2*n-1:0] acum_sig;
    logic [n:0]     parcial;
    logic [n:0]     suma_ext;
    logic [n-1:0]   resta;
    logic [n-1:0]   res_sig;
    logic           carry_sig;
    logic           desb_sig;

    // Cycles left after acceptance, minus one: the completion edge is where it reads zero.
    always_comb begin
        carga_contador = '0;
        case (alucontrol)
            OP_SLL:  carga_contador = (entrada2[cw-1:0] == '0) ? '0 : entrada2[cw-1:0] - cw'(1);
            OP_MUL:  carga_contador = cw'(n - 1);
            default: carga_contador = '0;
        endcase
    end

    always_comb begin
        suma_ext  = {1'b0, op_a} + {1'b0, op_b};
        resta     = op_a - op_b;
        parcial   = {1'b0, acumulador[2*n-1:n]} + {1'b0, (acumulador[0] ? op_a : {n{1'b0}})};
        acum_sig  = {parcial, acumulador[n-1:1]};
        desp_sig  = (op_b[cw-1:0] == '0) ? desplazado : (desplazado << 1);
        res_sig   = '0;
        carry_sig = 1'b0;
        desb_sig  = 1'b0;
        case (op_sel)
            OP_SUMA: begin
                res_sig   = suma_ext[n-1:0];
                carry_sig = suma_ext[n];
                desb_sig  = (op_a[n-1] == op_b[n-1]) && (suma_ext[n-1] != op_a[n-1]);
            end
            OP_RESTA: begin
                res_sig   = resta;
                carry_sig = (op_a >= op_b);
                desb_sig  = (op_a[n-1] != op_b[n-1]) && (resta[n-1] != op_a[n-1]);
            end
            OP_AND:  res_sig = op_a & op_b;
            OP_OR:   res_sig = op_a | op_b;
            OP_XOR:  res_sig = op_a ^ op_b;
            OP_SLT:  res_sig = {{(n-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL:  res_sig = desp_sig;
            OP_MUL: begin
                res_sig   = acum_sig[n-1:0];
                carry_sig = |acum_sig[2*n-1:n];
            end
            default: res_sig = '0;
        endcase
    end

    // Shift and multiply datapaths advance every busy cycle; only the selected one is reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= INACTIVO;
            contador       <= '0;
            op_a           <= '0;
            op_b           <= '0;
            op_sel         <= OP_SUMA;
            desplazado     <= '0;
            acumulador     <= '0;
            ocupado        <= 1'b0;
            listo          <= 1'b0;
            resultado      <= '0;
            carry          <= 1'b0;
            cero           <= 1'b1;
            negativo       <= 1'b0;
            desbordamiento <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (estado)
                INACTIVO: begin
                    if (inicio) begin
                        op_a       <= entrada1;
                        op_b       <= entrada2;
                        op_sel     <= alucontrol;
                        desplazado <= entrada1;
                        acumulador <= {{n{1'b0}}, entrada2};
                        contador   <= carga_contador;
                        ocupado    <= 1'b1;
                        estado     <= CALCULO;
                    end
                end
                CALCULO: begin
                    desplazado <= desp_sig;
                    acumulador <= acum_sig;
                    if (contador == '0) begin
                        resultado      <= res_sig;
                        carry          <= carry_sig;
                        desbordamiento <= desb_sig;
                        cero           <= (res_sig == '0);
                        negativo       <= res_sig[n-1];
                        listo          <= 1'b1;
                        ocupado        <= 1'b0;
                        estado         <= INACTIVO;
                    end else begin
                        contador <= contador - cw'(1);
                    end
                end
                default: estado <= INACTIVO;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_secuencial.sv
// Self-checking bench for alu_secuencial at n=8 and n=32: directed vector table,
// handshake/reset sequences and a randomized regression against an arithmetic model.
module tb_alu_secuencial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inicio8, inicio32;
    logic [7:0]  a8, b8;
    logic [31:0] a32, b32;
    logic [2:0]  op8, op32;
    logic        ocupado8, listo8, carry8, cero8, neg8, desb8;
    logic        ocupado32, listo32, carry32, cero32, neg32, desb32;
    logic [7:0]  res8;
    logic [31:0] res32;

    int total = 0;
    int bad = 0;
    int listos8 = 0;
    int listos32 = 0;
    int esperados = 0;

    logic        use32;
    logic        cur_ocupado, cur_listo;
    logic [31:0] cur_res;
    logic [3:0]  cur_flags;

    typedef struct {
        bit          wide;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
        int          exp_lat;
    } vector_t;

    vector_t tabla [16];

    always #5 clk = ~clk;

    alu_secuencial #(.n(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .inicio(inicio8), .entrada1(a8), .entrada2(b8),
        .alucontrol(op8), .ocupado(ocupado8), .listo(listo8), .resultado(res8),
        .carry(carry8), .cero(cero8), .negativo(neg8), .desbordamiento(desb8)
    );

    alu_secuencial #(.n(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .inicio(inicio32), .entrada1(a32), .entrada2(b32),
        .alucontrol(op32), .ocupado(ocupado32), .listo(listo32), .resultado(res32),
        .carry(carry32), .cero(cero32), .negativo(neg32), .desbordamiento(desb32)
    );

    always_comb begin
        if (use32) begin
            cur_ocupado = ocupado32;
            cur_listo   = listo32;
            cur_res     = res32;
            cur_flags   = {carry32, cero32, neg32, desb32};
        end else begin
            cur_ocupado = ocupado8;
            cur_listo   = listo8;
            cur_res     = {24'h0, res8};
            cur_flags   = {carry8, cero8, neg8, desb8};
        end
    end

    always @(negedge clk) begin
        if (listo8)  listos8++;
        if (listo32) listos32++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference computed from the arithmetic meaning of each operation at width w.
    function automatic void ref_alu(input int w, input logic [2:0] op,
                                    input longint unsigned a, input longint unsigned b,
                                    output longint unsigned res, output logic [3:0] flags,
                                    output int lat);
        longint unsigned mask, full;
        longint sa, sb, lo, hi, s;
        logic c, v;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(a);
        sb = longint'(b);
        if (((a >> (w - 1)) & 64'd1) != 0) sa = sa - (longint'(1) << w);
        if (((b >> (w - 1)) & 64'd1) != 0) sb = sb - (longint'(1) << w);
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        c = 1'b0;
        v = 1'b0;
        lat = 1;
        res = 0;
        case (op)
            3'd0: begin
                full = a + b;
                res = full & mask;
                c = ((full >> w) & 64'd1) != 0;
                s = sa + sb;
                v = (s < lo) || (s > hi);
            end
            3'd1: begin
                res = (a - b) & mask;
                c = (a >= b);
                s = sa - sb;
                v = (s < lo) || (s > hi);
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = (sa < sb) ? 64'd1 : 64'd0;
            3'd6: begin
                sh = int'(b % longint'(w));
                res = (a << sh) & mask;
                lat = (sh == 0) ? 1 : sh;
            end
            default: begin
                full = a * b;
                res = full & mask;
                c = (full >> w) != 0;
                lat = w;
            end
        endcase
        flags = {c, res == 0, ((res >> (w - 1)) & 64'd1) != 0, v};
    endfunction

    task automatic checkOutput(input string name, input longint unsigned act,
                               input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one request, holds inicio only for the accepting edge, then scrambles
    // the inputs and waits for listo while counting busy cycles.
    task automatic applyStimulus(input bit wide, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic [3:0] flags,
                                 output int lat);
        bit done;
        use32 = wide;
        if (wide) begin
            inicio32 = 1'b1; a32 = a; b32 = b; op32 = op;
        end else begin
            inicio8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; op8 = op;
        end
        @(posedge clk);
        @(negedge clk);
        inicio8 = 1'b0;
        inicio32 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
        a32 = $urandom; b32 = $urandom; op32 = 3'($urandom);
        lat = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (cur_listo) done = 1'b1;
            else begin
                if (cur_ocupado) lat++;
                @(negedge clk);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL listo timeout: op=%0d got no listo, expected one", op);
        end
        esperados++;
        res = cur_res;
        flags = cur_flags;
    endtask

    initial begin
        logic [31:0] r, a, b;
        logic [3:0]  f, ef;
        logic [2:0]  op;
        longint unsigned er;
        int lat, el, w, ciclos;

        tabla[0]  = '{1'b0, 3'd0, 32'h7F, 32'h01, 32'h80, 4'b0011, 1};
        tabla[1]  = '{1'b0, 3'd0, 32'hFF, 32'h01, 32'h00, 4'b1100, 1};
        tabla[2]  = '{1'b0, 3'd1, 32'h03, 32'h05, 32'hFE, 4'b0010, 1};
        tabla[3]  = '{1'b0, 3'd1, 32'h80, 32'h01, 32'h7F, 4'b1001, 1};
        tabla[4]  = '{1'b0, 3'd5, 32'h80, 32'h01, 32'h01, 4'b0000, 1};
        tabla[5]  = '{1'b0, 3'd2, 32'hF0, 32'h3C, 32'h30, 4'b0000, 1};
        tabla[6]  = '{1'b0, 3'd7, 32'h10, 32'h10, 32'h00, 4'b1100, 8};
        tabla[7]  = '{1'b0, 3'd6, 32'h03, 32'h07, 32'h80, 4'b0010, 7};
        tabla[8]  = '{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h1, 32'h1, 4'b0000, 1};
        tabla[9]  = '{1'b1, 3'd6, 32'h1, 32'h5, 32'h20, 4'b0000, 5};
        tabla[10] = '{1'b1, 3'd6, 32'h8000_0000, 32'h20, 32'h8000_0000, 4'b0010, 1};
        tabla[11] = '{1'b1, 3'd3, 32'h0F0F_0000, 32'hF0, 32'h0F0F_00F0, 4'b0000, 1};
        tabla[12] = '{1'b1, 3'd4, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0, 4'b0100, 1};
        tabla[13] = '{1'b1, 3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1100, 1};
        tabla[14] = '{1'b1, 3'd7, 32'h0001_0000, 32'h0001_0000, 32'h0, 4'b1100, 32};
        tabla[15] = '{1'b1, 3'd7, 32'd1234, 32'd5678, 32'd7006652, 4'b0000, 32};

        rst_n = 1'b0;
        inicio8 = 1'b0; inicio32 = 1'b0;
        a8 = '0; b8 = '0; op8 = '0;
        a32 = '0; b32 = '0; op32 = '0;
        use32 = 1'b0;
        #12;
        checkOutput("reset n8", {ocupado8, listo8, res8, carry8, cero8, neg8, desb8},
                    {2'b00, 8'h00, 4'b0100});
        checkOutput("reset n32", {ocupado32, listo32, res32, carry32, cero32, neg32, desb32},
                    {2'b00, 32'h0, 4'b0100});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tabla[i].wide, tabla[i].op, tabla[i].a, tabla[i].b, r, f, lat);
            checkOutput($sformatf("vec%0d res", i), r, tabla[i].exp_res);
            checkOutput($sformatf("vec%0d flags", i), f, tabla[i].exp_flags);
            checkOutput($sformatf("vec%0d latency", i), lat, tabla[i].exp_lat);
        end

        // Abort a multiply mid-flight with an asynchronous reset.
        inicio32 = 1'b1; op32 = 3'd7; a32 = 32'd99; b32 = 32'd77;
        @(posedge clk);
        @(negedge clk);
        inicio32 = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset mid-mul n32",
                    {ocupado32, listo32, res32, carry32, cero32, neg32, desb32},
                    {2'b00, 32'h0, 4'b0100});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 3'd0, 32'd5, 32'd7, r, f, lat);
        checkOutput("post-reset suma res", r, 32'd12);
        checkOutput("post-reset suma latency", lat, 1);

        // inicio held through a multiply with moving operands, then back-to-back issue.
        use32 = 1'b1;
        inicio32 = 1'b1; op32 = 3'd7; a32 = 32'd3; b32 = 32'd4;
        @(posedge clk);
        ciclos = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (listo32) break;
            ciclos++;
            a32 = $urandom;
            b32 = $urandom;
        end
        checkOutput("held-inicio listo seen", listo32, 1'b1);
        checkOutput("held-inicio mul res", res32, 32'd12);
        checkOutput("held-inicio busy cycles", ciclos, 32);
        checkOutput("not accepted on completion edge", ocupado32, 1'b0);
        op32 = 3'd0; a32 = 32'd10; b32 = 32'd20;
        @(posedge clk);
        @(negedge clk);
        checkOutput("accepted on listo cycle", ocupado32, 1'b1);
        inicio32 = 1'b0;
        @(negedge clk);
        checkOutput("back-to-back listo", listo32, 1'b1);
        checkOutput("back-to-back res", res32, 32'd30);
        esperados += 2;
        @(negedge clk);

        for (int pass = 0; pass < 2; pass++) begin
            w = (pass == 1) ? 32 : 8;
            for (int i = 0; i < 1500; i++) begin
                op = 3'($urandom_range(0, 7));
                a = $urandom;
                b = $urandom;
                if ($urandom_range(0, 4) == 0) a = (w == 8) ? 32'h80 : 32'h8000_0000;
                if ($urandom_range(0, 4) == 0) b = 32'hFFFF_FFFF;
                if ($urandom_range(0, 6) == 0) b = a;
                if (w == 8) begin
                    a = a & 32'hFF;
                    b = b & 32'hFF;
                end
                ref_alu(w, op, longint'(a), longint'(b), er, ef, el);
                applyStimulus(pass == 1, op, a, b, r, f, lat);
                checkOutput($sformatf("rnd n%0d op%0d a=%0h b=%0h res", w, op, a, b), r, er);
                checkOutput($sformatf("rnd n%0d op%0d a=%0h b=%0h flags", w, op, a, b), f, ef);
                checkOutput($sformatf("rnd n%0d op%0d latency", w, op), lat, el);
            end
        end

        repeat (3) @(negedge clk);
        checkOutput("listo count", listos8 + listos32, esperados);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
